// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - framed UART command parser driving the flash controller
module uart_cmd_parser #(
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 50000,
    parameter int         CNT_W       = 16
) (
    input  logic       CLK_50MHZ,
    input  logic       RST,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    output logic       fl_start,
    output logic       fl_rw,
    output logic [7:0] fl_addr,
    output logic [7:0] fl_wdata,
    input  logic [7:0] fl_rdata,
    input  logic       fl_done,
    output logic       busy,
    output logic [7:0] err_count
);

    localparam logic [7:0]       CMD_W   = 8'h57;
    localparam logic [7:0]       CMD_R   = 8'h52;
    localparam logic [7:0]       ACK     = 8'h06;
    localparam logic [7:0]       NAK     = 8'h15;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [3:0] {
        IDLE, GET_CMD, GET_ADDR, GET_DATA, GET_CSUM,
        FL_REQ, FL_WAIT, TX_ACK, TX_DATA, TX_NAK
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       cmd;
    logic [7:0]       addr;
    logic [7:0]       data;
    logic [7:0]       rdata;

    logic       is_w;
    logic       in_get;
    logic       timed_out;
    logic [7:0] csum_exp;
    logic [7:0] err_next;

    assign busy      = (state != IDLE);
    assign is_w      = (cmd == CMD_W);
    assign in_get    = (state == GET_CMD) || (state == GET_ADDR) ||
                       (state == GET_DATA) || (state == GET_CSUM);
    assign timed_out = (cnt == TO_LAST);
    // The data register is stale for reads, so it is masked out of the checksum.
    assign csum_exp  = cmd ^ addr ^ (is_w ? data : 8'h00);
    assign err_next  = (err_count == 8'hFF) ? err_count : err_count + 8'd1;

    always_ff @(posedge CLK_50MHZ or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            cnt       <= '0;
            cmd       <= 8'h00;
            addr      <= 8'h00;
            data      <= 8'h00;
            rdata     <= 8'h00;
            tx_start  <= 1'b0;
            tx_data   <= 8'h00;
            fl_start  <= 1'b0;
            fl_rw     <= 1'b0;
            fl_addr   <= 8'h00;
            fl_wdata  <= 8'h00;
            err_count <= 8'h00;
        end else begin
            tx_start <= 1'b0;
            fl_start <= 1'b0;
            if (in_get && !rx_valid) begin
                // A byte arriving in the expiry cycle takes the other branch and wins.
                if (timed_out) begin
                    state     <= IDLE;
                    err_count <= err_next;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (rx_valid && rx_data == SYNC_BYTE) begin
                            state <= GET_CMD;
                            cnt   <= '0;
                        end
                    end
                    GET_CMD: begin
                        cnt <= '0;
                        if (rx_data == CMD_W || rx_data == CMD_R) begin
                            cmd   <= rx_data;
                            state <= GET_ADDR;
                        end else begin
                            err_count <= err_next;
                            tx_start  <= 1'b1;
                            tx_data   <= NAK;
                            state     <= TX_NAK;
                        end
                    end
                    GET_ADDR: begin
                        cnt   <= '0;
                        addr  <= rx_data;
                        state <= is_w ? GET_DATA : GET_CSUM;
                    end
                    GET_DATA: begin
                        cnt   <= '0;
                        data  <= rx_data;
                        state <= GET_CSUM;
                    end
                    GET_CSUM: begin
                        cnt <= '0;
                        if (rx_data == csum_exp) begin
                            fl_start <= 1'b1;
                            fl_rw    <= is_w;
                            fl_addr  <= addr;
                            fl_wdata <= is_w ? data : 8'h00;
                            state    <= FL_REQ;
                        end else begin
                            err_count <= err_next;
                            tx_start  <= 1'b1;
                            tx_data   <= NAK;
                            state     <= TX_NAK;
                        end
                    end
                    FL_REQ: begin
                        cnt   <= '0;
                        state <= FL_WAIT;
                    end
                    FL_WAIT: begin
                        if (fl_done) begin
                            rdata    <= fl_rdata;
                            tx_start <= 1'b1;
                            tx_data  <= ACK;
                            state    <= TX_ACK;
                        end else if (timed_out) begin
                            err_count <= err_next;
                            tx_start  <= 1'b1;
                            tx_data   <= NAK;
                            state     <= TX_NAK;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    TX_ACK: begin
                        if (tx_done) begin
                            if (is_w) begin
                                state <= IDLE;
                            end else begin
                                tx_start <= 1'b1;
                                tx_data  <= rdata;
                                state    <= TX_DATA;
                            end
                        end
                    end
                    TX_DATA, TX_NAK: begin
                        if (tx_done) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
